// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write to FF46 starts a 160-byte copy from page {src,00..9F}
// into OAM at FE00..FE9F. Each byte takes one READ and one WRITE cycle.
module oam_dma (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Enable,
    input  logic [15:0] i_CPU_Address,
    input  logic [7:0]  i_CPU_Data,
    input  logic        i_CPU_Write,
    input  logic        i_CPU_Read,
    output logic [7:0]  o_CPU_Data,
    output logic        o_CPU_Block,
    output logic [15:0] o_Mem_Address,
    output logic        o_Mem_Read,
    output logic        o_Mem_Write,
    output logic [7:0]  o_Mem_Data,
    input  logic [7:0]  i_Mem_Data,
    output logic        o_Active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [15:0] DMA_REG  = 16'hFF46;
    localparam logic [7:0]  LAST_IDX = 8'h9F;

    state_t     state_reg, state_next;
    logic [7:0] page_reg, page_next;
    logic [7:0] src_reg, src_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] latch_reg, latch_next;
    logic       trigger;

    assign trigger = i_CPU_Write && (i_CPU_Address == DMA_REG);

    // A trigger restarts the engine from any state, ahead of the normal sequencing.
    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        src_next   = src_reg;
        idx_next   = idx_reg;
        latch_next = latch_reg;
        if (i_Enable) begin
            if (trigger) begin
                page_next  = i_CPU_Data;
                src_next   = (i_CPU_Data >= 8'hE0) ? (i_CPU_Data - 8'h20) : i_CPU_Data;
                idx_next   = 8'h00;
                state_next = START;
            end else begin
                case (state_reg)
                    IDLE:  state_next = IDLE;
                    START: state_next = READ;
                    READ: begin
                        latch_next = i_Mem_Data;
                        state_next = WRITE;
                    end
                    WRITE: begin
                        if (idx_reg == LAST_IDX) begin
                            state_next = IDLE;
                        end else begin
                            idx_next   = idx_reg + 8'h01;
                            state_next = READ;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg <= IDLE;
            page_reg  <= 8'hFF;
            src_reg   <= 8'h00;
            idx_reg   <= 8'h00;
            latch_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            page_reg  <= page_next;
            src_reg   <= src_next;
            idx_reg   <= idx_next;
            latch_reg <= latch_next;
        end
    end

    // Memory-side outputs decode registered state only, so they hold while disabled.
    always_comb begin
        o_Mem_Address = 16'h0000;
        o_Mem_Read    = 1'b0;
        o_Mem_Write   = 1'b0;
        o_Mem_Data    = 8'h00;
        case (state_reg)
            READ: begin
                o_Mem_Address = {src_reg, idx_reg};
                o_Mem_Read    = 1'b1;
            end
            WRITE: begin
                o_Mem_Address = {8'hFE, idx_reg};
                o_Mem_Write   = 1'b1;
                o_Mem_Data    = latch_reg;
            end
            default: ;
        endcase
    end

    assign o_Active    = (state_reg != IDLE);
    assign o_CPU_Block = o_Active && (i_CPU_Read || i_CPU_Write) && (i_CPU_Address < 16'hFF00);
    assign o_CPU_Data  = (i_CPU_Read && (i_CPU_Address == DMA_REG)) ? page_reg : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: scoreboard of expected memory transactions plus a table of CPU-side vectors.
`timescale 1ns/1ps
module tb_oam_dma;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Enable = 1'b1;
    logic [15:0] i_CPU_Address = 16'h0000;
    logic [7:0]  i_CPU_Data = 8'h00;
    logic        i_CPU_Write = 1'b0;
    logic        i_CPU_Read = 1'b0;
    logic [7:0]  o_CPU_Data;
    logic        o_CPU_Block;
    logic [15:0] o_Mem_Address;
    logic        o_Mem_Read;
    logic        o_Mem_Write;
    logic [7:0]  o_Mem_Data;
    logic [7:0]  i_Mem_Data;
    logic        o_Active;

    oam_dma dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
        .i_CPU_Address(i_CPU_Address), .i_CPU_Data(i_CPU_Data),
        .i_CPU_Write(i_CPU_Write), .i_CPU_Read(i_CPU_Read),
        .o_CPU_Data(o_CPU_Data), .o_CPU_Block(o_CPU_Block),
        .o_Mem_Address(o_Mem_Address), .o_Mem_Read(o_Mem_Read),
        .o_Mem_Write(o_Mem_Write), .o_Mem_Data(o_Mem_Data),
        .i_Mem_Data(i_Mem_Data), .o_Active(o_Active)
    );

    always #5 i_Clk = ~i_Clk;

    // Memory contents depend on both address bytes so a wrong source page is visible in the data.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign i_Mem_Data = mem_model(o_Mem_Address);

    function automatic logic [7:0] map_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        blk;
        logic        sel;
    } cpu_vec_t;

    txn_t     sb[$];
    cpu_vec_t vecs[10];
    int       n_checks = 0;
    int       n_pass = 0;
    int       act_cnt = 0;
    int       phase = 0;
    bit       en_div = 1'b0;
    logic [7:0] cur_page = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every strobe consumed on an enabled edge must match the head of the scoreboard.
    always @(negedge i_Clk) begin
        if (o_Active === 1'b1) act_cnt++;
        if ((o_Mem_Read === 1'b1 || o_Mem_Write === 1'b1) && i_Enable) begin
            if (sb.size() == 0) begin
                check("unexpected_txn", {o_Mem_Read, o_Mem_Write, o_Mem_Address}, 18'h0);
            end else begin
                txn_t e;
                e = sb.pop_front();
                check("mem_txn", {o_Mem_Read, o_Mem_Write, o_Mem_Address, o_Mem_Data},
                      {~e.wr, e.wr, e.addr, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
        if (en_div) begin
            phase = (phase == 2) ? 0 : phase + 1;
            i_Enable = (phase == 2);
        end else begin
            i_Enable = 1'b1;
        end
    endtask

    task automatic push_transfer(input logic [7:0] src);
        sb.delete();
        for (int i = 0; i < 160; i++) begin
            txn_t r, w;
            r.wr = 1'b0; r.addr = {src, 8'(i)}; r.data = 8'h00;
            w.wr = 1'b1; w.addr = {8'hFE, 8'(i)}; w.data = mem_model({src, 8'(i)});
            sb.push_back(r);
            sb.push_back(w);
        end
    endtask

    // Holds the FF46 write until it lands on an enabled edge, then loads the new expectation.
    task automatic cpu_write(input logic [7:0] d);
        bit en_was;
        int n;
        n = 0;
        i_CPU_Address = 16'hFF46;
        i_CPU_Data = d;
        i_CPU_Write = 1'b1;
        do begin
            en_was = i_Enable;
            tick();
            n++;
        end while (!en_was && n < 10);
        check("trigger_taken", {31'd0, en_was}, 32'd1);
        i_CPU_Write = 1'b0;
        i_CPU_Address = 16'h0000;
        i_CPU_Data = 8'h00;
        push_transfer(map_page(d));
        cur_page = d;
        act_cnt = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (o_Active && n < bound) begin
            tick();
            n++;
        end
        check("done_timeout", {31'd0, o_Active}, 32'd0);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic wait_write(input logic [15:0] a, input int bound);
        int n;
        n = 0;
        while (!(o_Mem_Write && o_Mem_Address == a && i_Enable) && n < bound) begin
            tick();
            n++;
        end
        check("reach_write", {15'd0, o_Mem_Write, o_Mem_Address}, {15'd0, 1'b1, a});
    endtask

    task automatic apply_table(input bit active);
        for (int i = 0; i < 10; i++) begin
            i_CPU_Read = vecs[i].rd;
            i_CPU_Write = vecs[i].wr;
            i_CPU_Address = vecs[i].addr;
            #1;
            check($sformatf("block_%0d", i), {31'd0, o_CPU_Block}, {31'd0, active & vecs[i].blk});
            check($sformatf("rdata_%0d", i), {24'd0, o_CPU_Data}, {24'd0, vecs[i].sel ? cur_page : 8'h00});
            tick();
        end
        i_CPU_Read = 1'b0;
        i_CPU_Write = 1'b0;
        i_CPU_Address = 16'h0000;
    endtask

    task automatic check_idle_outputs();
        check("idle_active", {31'd0, o_Active}, 32'd0);
        check("idle_strobes", {30'd0, o_Mem_Read, o_Mem_Write}, 32'd0);
        check("idle_addr", {16'd0, o_Mem_Address}, 32'd0);
        check("idle_mdata", {24'd0, o_Mem_Data}, 32'd0);
    endtask

    initial begin
        //            rd    wr    addr      blk   sel
        vecs[0] = '{1'b1, 1'b0, 16'h8000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'hFF80, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'hFF46, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'hC000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'hFF47, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'hFEFF, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'hFF45, 1'b0, 1'b0};

        // Reset state and idle CPU-side behaviour
        i_Rst = 1'b1;
        repeat (3) tick();
        i_Rst = 1'b0;
        check_idle_outputs();
        apply_table(1'b0);

        // Full copy from C1 with the clock always enabled
        cpu_write(8'hC1);
        check("start_active", {31'd0, o_Active}, 32'd1);
        check("start_nostrobe", {30'd0, o_Mem_Read, o_Mem_Write}, 32'd0);
        tick();
        check("first_read", {15'd0, o_Mem_Read, o_Mem_Address}, {15'd0, 1'b1, 16'hC100});
        apply_table(1'b1);
        wait_idle(400);
        check("active_len", act_cnt, 321);
        apply_table(1'b0);

        // Mapped page E3 -> C3, read-back during the copy
        cpu_write(8'hE3);
        i_CPU_Read = 1'b1;
        i_CPU_Address = 16'hFF46;
        #1;
        check("readback_e3", {24'd0, o_CPU_Data}, 32'h000000E3);
        i_CPU_Read = 1'b0;
        i_CPU_Address = 16'h0000;
        wait_idle(400);

        // FF maps to DF, then a restart on a READ cycle with E0 (maps to C0)
        cpu_write(8'hFF);
        tick();
        check("read_df", {15'd0, o_Mem_Read, o_Mem_Address}, {15'd0, 1'b1, 16'hDF00});
        cpu_write(8'hE0);
        tick();
        check("read_c0", {15'd0, o_Mem_Read, o_Mem_Address}, {15'd0, 1'b1, 16'hC000});
        wait_idle(400);

        // Restart during START: START repeats, then reads the new page
        cpu_write(8'hC5);
        cpu_write(8'hC6);
        check("restart_start", {30'd0, o_Active, o_Mem_Read}, {30'd0, 1'b1, 1'b0});
        tick();
        check("read_c6", {15'd0, o_Mem_Read, o_Mem_Address}, {15'd0, 1'b1, 16'hC600});
        wait_idle(400);

        // Restart on the WRITE edge of idx 10: FE10 keeps page-80 data, then copy from 90
        cpu_write(8'h80);
        wait_write(16'hFE10, 100);
        cpu_write(8'h90);
        check("restart_write", {30'd0, o_Active, o_Mem_Write}, {30'd0, 1'b1, 1'b0});
        tick();
        check("read_9000", {15'd0, o_Mem_Read, o_Mem_Address}, {15'd0, 1'b1, 16'h9000});
        wait_idle(400);

        // Enable asserted one cycle in three stretches the transfer threefold
        en_div = 1'b1;
        phase = 0;
        tick();
        cpu_write(8'hC1);
        wait_idle(1200);
        check("active_len_div3", act_cnt, 963);

        // Reset on the WRITE cycle of idx 50 aborts the copy
        cpu_write(8'hC2);
        wait_write(16'hFE50, 600);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        sb.delete();
        check_idle_outputs();
        i_CPU_Read = 1'b1;
        i_CPU_Address = 16'hFF46;
        #1;
        check("readback_after_rst", {24'd0, o_CPU_Data}, 32'h000000FF);
        i_CPU_Read = 1'b0;
        i_CPU_Address = 16'h0000;
        en_div = 1'b0;
        begin
            int strobes;
            strobes = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (o_Mem_Read || o_Mem_Write || o_Active) strobes++;
            end
            check("no_write_after_rst", strobes, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
